// File: rtl/shared_mem_arbiter.sv
// shared_mem_arbiter
//   Round-robin arbiter that lets NUM_CORES cores share a single memory port.
//   A three-state FSM (IDLE -> BUSY -> DONE) serves one transaction at a time.
//   In BUSY the request is presented to memory until mem_ready arrives or the
//   optional timeout expires. In DONE a single-cycle ack (with error flag) is
//   returned to the granted core.
//
// Ports
//   clk, rst     : clock and synchronous active-high reset
//   core_req     : per-core request level
//   core_we      : per-core write enable
//   core_addr    : per-core byte address, core i at [i*ADDR_W +: ADDR_W]
//   core_wdata   : per-core write data, core i at [i*DATA_W +: DATA_W]
//   core_ack     : one-hot completion pulse to the granted core
//   core_err     : 1 when the acked transaction was aborted by timeout
//   core_rdata   : read data broadcast to all cores, valid with core_ack
//   mem_req      : memory request, high for every BUSY cycle
//   mem_we       : memory write enable
//   mem_addr     : word-aligned memory address
//   mem_wdata    : memory write data
//   mem_rdata    : memory read data
//   mem_ready    : memory completion strobe
//   grant_id     : index of the current or last granted core
//   busy         : FSM is not in IDLE
module shared_mem_arbiter #(
  parameter int NUM_CORES = 4,
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int TIMEOUT   = 255
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CORES-1:0]           core_req,
  input  logic [NUM_CORES-1:0]           core_we,
  input  logic [NUM_CORES*ADDR_W-1:0]    core_addr,
  input  logic [NUM_CORES*DATA_W-1:0]    core_wdata,
  output logic [NUM_CORES-1:0]           core_ack,
  output logic                           core_err,
  output logic [DATA_W-1:0]              core_rdata,
  output logic                           mem_req,
  output logic                           mem_we,
  output logic [ADDR_W-1:0]              mem_addr,
  output logic [DATA_W-1:0]              mem_wdata,
  input  logic [DATA_W-1:0]              mem_rdata,
  input  logic                           mem_ready,
  output logic [$clog2(NUM_CORES)-1:0]   grant_id,
  output logic                           busy
);

  localparam int GID_W   = $clog2(NUM_CORES);
  localparam int ALIGN_W = $clog2(DATA_W / 8);
  // A zero-width counter is not legal, so a disabled timeout still keeps one bit.
  localparam int CNT_W   = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  localparam logic [ADDR_W-1:0] ALIGN_MASK = ~((ADDR_W'(1) << ALIGN_W) - ADDR_W'(1));
  localparam logic [CNT_W-1:0]  TMO_MAX    = CNT_W'(TIMEOUT);
  localparam logic [GID_W-1:0]  LAST_CORE  = GID_W'(NUM_CORES - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [GID_W-1:0]  last_grant;
  logic [CNT_W-1:0]  tmo_cnt;
  logic              err_r;
  logic              tmo_hit;
  logic              win_found;
  logic [GID_W-1:0]  win_id;
  int                idx;

  // Round-robin search starting just after the previous winner.
  always_comb begin
    win_found = 1'b0;
    win_id    = '0;
    idx       = 0;
    for (int i = 1; i <= NUM_CORES; i++) begin
      idx = (int'(last_grant) + i) % NUM_CORES;
      if (!win_found && core_req[idx]) begin
        win_found = 1'b1;
        win_id    = GID_W'(idx);
      end
    end
  end

  assign tmo_hit = (TIMEOUT != 0) && (tmo_cnt == TMO_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (win_found) state_nxt = BUSY;
      BUSY:    if (mem_ready || tmo_hit) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Grant capture, timeout counting and completion data.
  always_ff @(posedge clk) begin
    if (rst) begin
      grant_id   <= '0;
      last_grant <= LAST_CORE;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      core_rdata <= '0;
      err_r      <= 1'b0;
      tmo_cnt    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (win_found) begin
            grant_id  <= win_id;
            mem_we    <= core_we[win_id];
            mem_addr  <= core_addr[int'(win_id)*ADDR_W +: ADDR_W] & ALIGN_MASK;
            mem_wdata <= core_wdata[int'(win_id)*DATA_W +: DATA_W];
            tmo_cnt   <= '0;
          end
        end
        BUSY: begin
          if (tmo_cnt != TMO_MAX) tmo_cnt <= tmo_cnt + CNT_W'(1);
          // mem_ready takes priority over a coincident timeout.
          if (mem_ready) begin
            core_rdata <= mem_we ? '0 : mem_rdata;
            err_r      <= 1'b0;
          end else if (tmo_hit) begin
            core_rdata <= '0;
            err_r      <= 1'b1;
          end
        end
        DONE: begin
          last_grant <= grant_id;
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    core_ack = '0;
    if (state == DONE) core_ack[grant_id] = 1'b1;
  end

  assign core_err = (state == DONE) && err_r;
  assign mem_req  = (state == BUSY);
  assign busy     = (state != IDLE);

endmodule

// File: tb/tb_shared_mem_arbiter.sv
module tb_shared_mem_arbiter;

  localparam int NC = 4;
  localparam int AW = 32;
  localparam int DW = 32;

  logic              clk = 1'b0;
  logic              rst;
  logic [NC-1:0]     core_req;
  logic [NC-1:0]     core_we;
  logic [NC*AW-1:0]  core_addr;
  logic [NC*DW-1:0]  core_wdata;
  logic [NC-1:0]     core_ack;
  logic              core_err;
  logic [DW-1:0]     core_rdata;
  logic              mem_req;
  logic              mem_we;
  logic [AW-1:0]     mem_addr;
  logic [DW-1:0]     mem_wdata;
  logic [DW-1:0]     mem_rdata;
  logic              mem_ready;
  logic [1:0]        grant_id;
  logic              busy;

  int n_tests = 0;
  int n_fail  = 0;

  shared_mem_arbiter #(
    .NUM_CORES(NC), .ADDR_W(AW), .DATA_W(DW), .TIMEOUT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
    .core_ack(core_ack), .core_err(core_err), .core_rdata(core_rdata),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .grant_id(grant_id), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          core;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          delay;   // BUSY cycles before mem_ready
    logic [31:0] rdata;   // value on mem_rdata with mem_ready
    logic [3:0]  ack;
    logic [31:0] maddr;
    logic        err;
    logic [31:0] exp_rd;
  } vec_t;

  vec_t vecs[5];

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic fill_background();
    for (int i = 0; i < NC; i++) begin
      core_addr[i*AW +: AW]  = 32'hFFFF_FFF0 ^ 32'(i);
      core_wdata[i*DW +: DW] = 32'h5555_0000 | 32'(i);
    end
    core_we = 4'b1111;
  endtask

  initial begin
    vecs[0] = '{2, 1'b0, 32'h0000_0103, 32'h0,         3, 32'hDEAD_BEEF, 4'b0100, 32'h0000_0100, 1'b0, 32'hDEAD_BEEF};
    vecs[1] = '{1, 1'b1, 32'h0000_2000, 32'h1234_5678, 2, 32'hCAFE_F00D, 4'b0010, 32'h0000_2000, 1'b0, 32'h0};
    vecs[2] = '{3, 1'b0, 32'h0000_03FF, 32'h0,         0, 32'hA5A5_5A5A, 4'b1000, 32'h0000_03FC, 1'b0, 32'hA5A5_5A5A};
    vecs[3] = '{0, 1'b1, 32'h0000_0007, 32'hFFFF_0000, 1, 32'h0,         4'b0001, 32'h0000_0004, 1'b0, 32'h0};
    // mem_ready in the same cycle the timeout counter reaches 4
    vecs[4] = '{2, 1'b0, 32'h0000_0055, 32'h0,         4, 32'h0BAD_C0DE, 4'b0100, 32'h0000_0054, 1'b0, 32'h0BAD_C0DE};

    rst = 1'b1; core_req = '0; core_we = '0; core_addr = '0; core_wdata = '0;
    mem_rdata = 32'h1111_1111; mem_ready = 1'b0;
    tick(); tick();
    rst = 1'b0;

    chk("rst_busy",       64'(busy),       64'(0));
    chk("rst_mem_req",    64'(mem_req),    64'(0));
    chk("rst_core_ack",   64'(core_ack),   64'(0));
    chk("rst_core_err",   64'(core_err),   64'(0));
    chk("rst_core_rdata", 64'(core_rdata), 64'(0));
    chk("rst_mem_addr",   64'(mem_addr),   64'(0));
    chk("rst_mem_wdata",  64'(mem_wdata),  64'(0));
    chk("rst_mem_we",     64'(mem_we),     64'(0));
    chk("rst_grant_id",   64'(grant_id),   64'(0));

    // Round robin: all cores request continuously.
    begin
      int exp_order[5] = '{0, 1, 2, 3, 0};
      logic [3:0] seen = '0;
      fill_background();
      core_we = '0;
      core_req = 4'b1111;
      tick();
      for (int k = 0; k < 5; k++) begin
        chk("rr_mem_req", 64'(mem_req), 64'(1));
        chk("rr_grant",   64'(grant_id), 64'(exp_order[k]));
        if (k < 4) begin
          chk("rr_not_regranted", 64'(seen[grant_id]), 64'(0));
          seen[grant_id] = 1'b1;
        end
        mem_ready = 1'b1;
        tick();
        mem_ready = 1'b0;
        chk("rr_ack", 64'(core_ack), 64'(4'b0001 << exp_order[k]));
        if (k == 4) core_req = '0;
        tick();
        chk("rr_idle", 64'(busy), 64'(0));
        if (k < 4) tick();
      end
      chk("rr_all_served", 64'(seen), 64'(4'b1111));
    end

    // mem_ready while idle must be ignored.
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    chk("idle_ready_busy",    64'(busy),     64'(0));
    chk("idle_ready_ack",     64'(core_ack), 64'(0));

    // Table-driven single transactions.
    for (int v = 0; v < 5; v++) begin
      fill_background();
      core_we[vecs[v].core]                = vecs[v].we;
      core_addr[vecs[v].core*AW +: AW]     = vecs[v].addr;
      core_wdata[vecs[v].core*DW +: DW]    = vecs[v].wdata;
      core_req = 4'b0001 << vecs[v].core;
      mem_rdata = 32'h1111_1111;
      tick();
      chk("tv_grant", 64'(grant_id), 64'(vecs[v].core));
      for (int d = 0; d <= vecs[v].delay; d++) begin
        chk("tv_mem_req",   64'(mem_req),   64'(1));
        chk("tv_mem_addr",  64'(mem_addr),  64'(vecs[v].maddr));
        chk("tv_mem_we",    64'(mem_we),    64'(vecs[v].we));
        if (vecs[v].we) chk("tv_mem_wdata", 64'(mem_wdata), 64'(vecs[v].wdata));
        chk("tv_no_ack",    64'(core_ack),  64'(0));
        if (d == vecs[v].delay) begin
          mem_ready = 1'b1;
          mem_rdata = vecs[v].rdata;
        end
        tick();
      end
      mem_ready = 1'b0;
      mem_rdata = 32'h1111_1111;
      core_req  = '0;
      chk("tv_ack",    64'(core_ack),   64'(vecs[v].ack));
      chk("tv_err",    64'(core_err),   64'(vecs[v].err));
      chk("tv_rdata",  64'(core_rdata), 64'(vecs[v].exp_rd));
      chk("tv_mem_req_done", 64'(mem_req), 64'(0));
      tick();
      chk("tv_idle",   64'(busy),     64'(0));
      chk("tv_ack_off", 64'(core_ack), 64'(0));
    end

    // Timeout: mem_ready never comes.
    begin
      int cnt = 0;
      fill_background();
      core_we = '0;
      core_req = 4'b0001;
      tick();
      while (mem_req && cnt < 20) begin
        cnt++;
        tick();
      end
      core_req = '0;
      chk("to_mem_req_cycles", 64'(cnt),        64'(5));
      chk("to_ack",            64'(core_ack),   64'(4'b0001));
      chk("to_err",            64'(core_err),   64'(1));
      chk("to_rdata",          64'(core_rdata), 64'(0));
      chk("to_busy_done",      64'(busy),       64'(1));
      tick();
      chk("to_busy_fall",      64'(busy),       64'(0));
      chk("to_ack_off",        64'(core_ack),   64'(0));
    end

    // Reset in the second BUSY cycle.
    fill_background();
    core_we = '0;
    core_req = 4'b0001;
    tick();
    chk("rm_busy1", 64'(mem_req), 64'(1));
    tick();
    chk("rm_busy2", 64'(mem_req), 64'(1));
    rst = 1'b1;
    mem_ready = 1'b1;
    tick();
    rst = 1'b0;
    mem_ready = 1'b0;
    core_req = '0;
    chk("rm_mem_req",   64'(mem_req),    64'(0));
    chk("rm_busy",      64'(busy),       64'(0));
    chk("rm_ack",       64'(core_ack),   64'(0));
    chk("rm_rdata",     64'(core_rdata), 64'(0));
    core_req = 4'b1000;
    tick();
    chk("rm_grant3",    64'(grant_id),   64'(3));
    chk("rm_req3",      64'(mem_req),    64'(1));
    chk("rm_addr3",     64'(mem_addr),   64'(32'hFFFF_FFF0 ^ 32'd3) & 64'hFFFF_FFFC);
    mem_ready = 1'b1;
    mem_rdata = 32'h7777_8888;
    tick();
    mem_ready = 1'b0;
    core_req = '0;
    chk("rm_ack3",      64'(core_ack),   64'(4'b1000));
    chk("rm_rdata3",    64'(core_rdata), 64'(32'h7777_8888));
    tick();
    chk("rm_idle",      64'(busy),       64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/shared_mem_arbiter.md
SHARED_MEM_ARBITER -- requirements
Module: shared_mem_arbiter

Interface
REQ-001 Parameter NUM_CORES, default 4: number of requesting cores; legal range 2..8.
REQ-002 Parameter ADDR_W, default 32: byte address width.
REQ-003 Parameter DATA_W, default 32: word width, equal to the cache line size.
REQ-004 Parameter TIMEOUT, default 255: maximum number of BUSY cycles before abort; 0 disables the timeout.
REQ-005 Port clk  in  1: the single clock; all logic is on its rising edge.
REQ-006 Port rst  in  1: reset, synchronous and active-high.
REQ-007 Port core_req  in  NUM_CORES: per-core request, level.
REQ-008 Port core_we  in  NUM_CORES: per-core write enable (1 = write).
REQ-009 Port core_addr  in  NUM_CORES*ADDR_W: per-core byte address; core i occupies bits [i*ADDR_W +: ADDR_W].
REQ-010 Port core_wdata  in  NUM_CORES*DATA_W: per-core write data, packed the same way.
REQ-011 Port core_ack  out  NUM_CORES: one-cycle completion pulse to the granted core.
REQ-012 Port core_err  out  1: qualifies core_ack; 1 = transaction aborted by timeout.
REQ-013 Port core_rdata  out  DATA_W: read data, broadcast to all cores, valid while core_ack is high.
REQ-014 Port mem_req  out  1: request to the shared memory port.
REQ-015 Port mem_we  out  1: write enable to the shared memory port.
REQ-016 Port mem_addr  out  ADDR_W: address to the shared memory port; word-aligned.
REQ-017 Port mem_wdata  out  DATA_W: write data to the shared memory port.
REQ-018 Port mem_rdata  in  DATA_W: read data from the shared memory port.
REQ-019 Port mem_ready  in  1: memory completion, one cycle.
REQ-020 Port grant_id  out  $clog2(NUM_CORES): index of the current or last granted core.
REQ-021 Port busy  out  1: high while the FSM is not in IDLE.

Function
REQ-022 The FSM SHALL have exactly three states: IDLE, BUSY and DONE.
REQ-023 IDLE, with any core_req bit set: select the winner, register its we, addr and wdata, update grant_id, and go to BUSY.
- Search order for the winner is last_grant+1, last_grant+2, ... wrapping modulo NUM_CORES (round-robin).
REQ-024 IDLE, with no core_req bit set: remain in IDLE.
REQ-025 mem_req SHALL be high in every BUSY cycle and only in BUSY cycles.
REQ-026 mem_we, mem_addr and mem_wdata SHALL hold the values latched at grant for the whole of BUSY.
REQ-027 mem_addr[$clog2(DATA_W/8)-1:0] SHALL be forced to 0 (word alignment); the upper address bits pass through unchanged.
REQ-028 BUSY, with mem_ready=1: register mem_rdata (reads) or 0 (writes) into core_rdata, set err=0, and go to DONE.
REQ-029 BUSY, with timeout counter == TIMEOUT, TIMEOUT != 0 and mem_ready=0: set core_rdata=0 and err=1, and go to DONE.
- The counter is cleared on entry to BUSY and increments each BUSY cycle.
- Its width is $clog2(TIMEOUT+1), and it saturates.
REQ-030 If mem_ready and the timeout coincide, mem_ready SHALL win (err=0).
REQ-031 DONE: pulse core_ack[grant_id] and drive core_err for exactly one cycle, set last_grant=grant_id, and go to IDLE.
REQ-032 core_req SHALL NOT be sampled during DONE.
- Requesters drop req on the cycle after observing ack.
- A new request from any core is arbitrated in the following IDLE cycle.
REQ-033 Latency: request seen in IDLE at cycle 0 -> mem_req high at cycle 1 -> mem_ready at cycle k -> core_ack at cycle k+1 -> IDLE at cycle k+2.
REQ-034 mem_ready in IDLE or DONE SHALL be ignored.
REQ-035 If the granted core drops core_req during BUSY, the transaction SHALL still complete and core_ack SHALL still pulse.
REQ-036 Requests from non-granted cores SHALL be held pending, not lost.
REQ-037 At most one core_ack bit SHALL be high in any cycle.
REQ-038 busy SHALL equal (state != IDLE).

Reset
REQ-039 On rst=1 at a clock edge, the block SHALL initialise as follows:
- state = IDLE;
- mem_req, core_ack, core_err = 0;
- core_rdata, mem_addr, mem_wdata, mem_we = 0;
- grant_id = 0;
- last_grant = NUM_CORES-1, so core 0 has first priority;
- timeout counter = 0.
REQ-040 Reset asserted during BUSY or DONE SHALL abort the transaction.
- No core_ack is issued.
- mem_req is low in the cycle after the reset edge.
REQ-041 No core_req SHALL be sampled in a cycle where rst=1.

Verification
REQ-042 The bench SHALL cover a single read: core 2 reads address 0x103 and mem_ready arrives 3 cycles after mem_req.
- mem_addr = 0x100.
- core_ack = 4'b0100, 4 cycles after mem_req rises.
- core_rdata equals mem_rdata (0xDEADBEEF), with err=0.
REQ-043 The bench SHALL cover round-robin fairness: all 4 cores hold req continuously after reset.
- Grant order is 0,1,2,3,0.
- No core is granted twice before every core has been granted once.
REQ-044 The bench SHALL cover a timeout: TIMEOUT=4 and mem_ready is never asserted.
- mem_req is high for 5 cycles.
- core_ack pulses with core_err=1 and core_rdata=0.
- busy falls one cycle later.
REQ-045 The bench SHALL cover mem_ready coinciding with the timeout.
- core_err=0.
- core_rdata = mem_rdata.
REQ-046 The bench SHALL cover reset mid-operation: rst is asserted in the 2nd BUSY cycle.
- The next cycle shows mem_req=0, busy=0 and no core_ack.
- A fresh request from core 3 is then granted with grant_id=3.
REQ-047 The bench SHALL cover a write: core 1 writes 0x12345678 to 0x2000.
- mem_we=1 and mem_wdata=0x12345678 are held stable through BUSY.
- core_ack = 4'b0010, with core_rdata=0.
